// File: rtl/data_mem_pipe_if.sv
// Request/response bus for data_mem_pipe.
// master = requester (drives req_*), slave = memory block (drives req_ready and rsp_*).
interface data_mem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: RV32I-style load/store data memory with a configurable read latency.
// Stores write on the acceptance edge. Loads sample the array on the acceptance edge
// and answer RD_LATENCY cycles later.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses are errors. Otherwise the offending low address bits are forced to zero.
module data_mem_pipe #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_pipe_if.slave bus
);
  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lanes touched by a store of the given size at the (possibly forced) offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every candidate lane carries the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   store_lanes = {4{wdata[7:0]}};
      2'b01:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  // Extract and extend the addressed byte/halfword/word from a memory word.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_extend = word;
      3'b100:  load_extend = {24'h000000, sh[7:0]};
      3'b101:  load_extend = {16'h0000, sh[15:0]};
      default: load_extend = 32'h00000000;
    endcase
  endfunction

  // The array is not touched by rst; it starts out all zero.
  logic [31:0] mem_r [DEPTH] = '{default: 32'h00000000};

  state_t                  state_r;
  logic [1:0]              cnt_r;
  logic                    ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_err_r;
  logic [31:0]             rsp_data_r;
  logic [31:0]             pend_data_r;

  logic                    err_s;
  logic                    misalign_s;
  logic [1:0]              off_s;
  logic                    accept_s;
  logic                    write_en_s;
  logic                    direct_s;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic [3:0]              mask_s;
  logic [31:0]             wlanes_s;
  logic [31:0]             ld_data_s;
  logic [31:0]             resp_data_s;
  logic                    unused_addr_s;

  // Upper address bits only alias the array; they are intentionally dropped.
  assign unused_addr_s = ^bus.req_addr[31:ADDR_WIDTH+2];

  // Decode legality, alignment and effective byte offset of the presented request.
  always_comb begin
    err_s      = 1'b0;
    off_s      = bus.req_addr[1:0];
    misalign_s = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: err_s = 1'b0;
      3'b100, 3'b101:         err_s = bus.req_we;
      default:                err_s = 1'b1;
    endcase
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    err_s = err_s | misalign_s;
`else
    case (bus.req_funct3[1:0])
      2'b01:   off_s = {bus.req_addr[1], 1'b0};
      2'b10:   off_s = 2'b00;
      default: off_s = bus.req_addr[1:0];
    endcase
`endif
  end

  assign accept_s   = bus.req_valid && ready_r && !rst;
  assign write_en_s = accept_s && bus.req_we && !err_s;
  assign direct_s   = bus.req_we || err_s || (RD_LATENCY == 1);
  assign idx_s      = bus.req_addr[ADDR_WIDTH+1:2];
  assign mask_s     = lane_mask(bus.req_funct3, off_s);
  assign wlanes_s   = store_lanes(bus.req_funct3, bus.req_wdata);
  assign ld_data_s  = load_extend(bus.req_funct3, off_s, mem_r[idx_s]);

  // Stores and errors answer with zero data; loads answer with the extended word.
  always_comb begin
    if (err_s || bus.req_we) begin
      resp_data_s = 32'h00000000;
    end else begin
      resp_data_s = ld_data_s;
    end
  end

  // Byte-lane write into the array on the acceptance edge.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered ready and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= 32'h00000000;
      pend_data_r <= 32'h00000000;
    end else begin
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (accept_s) begin
            if (direct_s) begin
              state_r     <= ST_RESP;
              ready_r     <= 1'b1;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= err_s;
              rsp_data_r  <= resp_data_s;
            end else begin
              state_r     <= ST_WAIT;
              ready_r     <= 1'b0;
              rsp_valid_r <= 1'b0;
              cnt_r       <= WAIT_LOAD;
              pend_data_r <= ld_data_s;
            end
          end else begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 2'd1) begin
            state_r     <= ST_RESP;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= pend_data_r;
            cnt_r       <= 2'd0;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ready_r     <= 1'b1;
          rsp_valid_r <= 1'b0;
          cnt_r       <= 2'd0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;
endmodule

// File: tb/tb_data_mem_pipe.sv
// Testbench for data_mem_pipe: two instances (RD_LATENCY 1 and 3) checked every cycle
// against a byte-array / pending-response model, plus directed literal checks.
module tb_data_mem_pipe;
  localparam int AW    = 10;
  localparam int BYTES = 4 * (2 ** AW);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_v [2];
  logic        req_we_v    [2];
  logic [2:0]  f3_v        [2];
  logic [31:0] addr_v      [2];
  logic [31:0] wdata_v     [2];
  logic        ready_v     [2];
  logic        rsp_valid_v [2];
  logic        rsp_err_v   [2];
  logic [31:0] rsp_data_v  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    data_mem_pipe_if bus ();
    assign bus.req_valid  = req_valid_v[g];
    assign bus.req_we     = req_we_v[g];
    assign bus.req_funct3 = f3_v[g];
    assign bus.req_addr   = addr_v[g];
    assign bus.req_wdata  = wdata_v[g];
    assign ready_v[g]     = bus.req_ready;
    assign rsp_valid_v[g] = bus.rsp_valid;
    assign rsp_err_v[g]   = bus.rsp_err;
    assign rsp_data_v[g]  = bus.rsp_data;
    data_mem_pipe #(.ADDR_WIDTH(AW), .RD_LATENCY((g == 0) ? 1 : 3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0]  mm [2][BYTES];
  int          cyc = 0;
  bit          pend_v    [2];
  int          pend_due  [2];
  logic [31:0] pend_data [2];
  bit          pend_err  [2];
  int          acc_cnt   [2];
  int          acc_cyc   [2];

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: actual %h required %h at cycle %0d", name, l, act, exp, cyc);
    end
  endtask

  // Apply one accepted request to the byte model and return its response.
  task automatic model_access(input int l, input bit we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] d, output bit e);
    bit legal, misal;
    int size;
    logic [31:0] base, v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    misal = (size > 1) && ((a % size) != 0);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    e = !legal || misal;
`else
    e = !legal;
`endif
    base = (a & ~(32'(size) - 32'd1)) % BYTES;
    d = 32'h0;
    if (!e && we) begin
      for (int i = 0; i < size; i++) mm[l][base + i] = wd[8*i +: 8];
    end
    if (!e && !we) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mm[l][base + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
      d = v;
    end
  endtask

  // Model update at each rising edge: acceptance, retirement of responses, reset.
  always @(posedge clk) begin
    int n;
    n = cyc + 1;
    for (int l = 0; l < 2; l++) begin
      bit rdy;
      logic [31:0] d;
      bit e;
      rdy = !(pend_v[l] && pend_due[l] > cyc);
      if (rst) begin
        pend_v[l] = 1'b0;
      end else begin
        if (pend_v[l] && pend_due[l] < n) pend_v[l] = 1'b0;
        if (req_valid_v[l] && rdy) begin
          model_access(l, req_we_v[l], f3_v[l], addr_v[l], wdata_v[l], d, e);
          pend_v[l]    = 1'b1;
          pend_data[l] = d;
          pend_err[l]  = e;
          pend_due[l]  = n + ((req_we_v[l] || e) ? 0 : lat_of(l) - 1);
          acc_cnt[l]++;
          acc_cyc[l]   = n;
        end
      end
    end
    cyc = n;
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < 2; l++) begin
        bit ev, er;
        ev = pend_v[l] && (pend_due[l] == cyc);
        er = !(pend_v[l] && pend_due[l] > cyc);
        check("req_ready", l, 32'(ready_v[l]), 32'(er));
        check("rsp_valid", l, 32'(rsp_valid_v[l]), 32'(ev));
        if (ev) begin
          check("rsp_data", l, rsp_data_v[l], pend_data[l]);
          check("rsp_err", l, 32'(rsp_err_v[l]), 32'(pend_err[l]));
        end
      end
    end
  end

  task automatic wait_accept(input int l, input int a0);
    int k;
    k = 0;
    while (acc_cnt[l] == a0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("accept_seen", l, 32'(acc_cnt[l] - a0), 32'd1);
  endtask

  task automatic wait_rsp(input int l, output logic [31:0] d, output bit e, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    d   = 32'h0;
    e   = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid_v[l]) begin
        got = 1'b1;
        d   = rsp_data_v[l];
        e   = rsp_err_v[l];
        lat = k;
      end
    end
    check("rsp_seen", l, 32'(got), 32'd1);
  endtask

  task automatic do_req(input int l, input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] d, output bit e, output int lat);
    int a0;
    @(negedge clk);
    req_valid_v[l] = 1'b1;
    req_we_v[l]    = we;
    f3_v[l]        = f3;
    addr_v[l]      = a;
    wdata_v[l]     = wd;
    a0 = acc_cnt[l];
    wait_accept(l, a0);
    req_valid_v[l] = 1'b0;
    wait_rsp(l, d, e, lat);
  endtask

  task automatic directed(input int l);
    logic [31:0] d;
    bit e;
    int lat, a0, c1;
    do_req(l, 1'b1, 3'b000, 32'h0, 32'h000000A5, d, e, lat);
    check("sb_lat", l, 32'(lat), 32'd1);
    do_req(l, 1'b0, 3'b000, 32'h0, 32'h0, d, e, lat);
    check("lb_data", l, d, 32'hFFFFFFA5);
    check("lb_lat", l, 32'(lat), 32'(lat_of(l)));
    do_req(l, 1'b0, 3'b100, 32'h0, 32'h0, d, e, lat);
    check("lbu_data", l, d, 32'h000000A5);
    do_req(l, 1'b1, 3'b001, 32'h6, 32'h0000ABCD, d, e, lat);
    do_req(l, 1'b0, 3'b001, 32'h6, 32'h0, d, e, lat);
    check("lh_data", l, d, 32'hFFFFABCD);
    do_req(l, 1'b0, 3'b101, 32'h6, 32'h0, d, e, lat);
    check("lhu_data", l, d, 32'h0000ABCD);
    do_req(l, 1'b0, 3'b010, 32'h4, 32'h0, d, e, lat);
    check("lw4_data", l, d, 32'hABCD0000);
    do_req(l, 1'b1, 3'b010, 32'h8, 32'h12345678, d, e, lat);
    do_req(l, 1'b0, 3'b000, 32'h9, 32'h0, d, e, lat);
    check("lb9_data", l, d, 32'h00000056);
    do_req(l, 1'b0, 3'b010, 32'h8 + 32'(BYTES), 32'h0, d, e, lat);
    check("lw_wrap", l, d, 32'h12345678);
    // back-to-back store then load with req_valid held high
    @(negedge clk);
    req_valid_v[l] = 1'b1; req_we_v[l] = 1'b1; f3_v[l] = 3'b010;
    addr_v[l] = 32'h10; wdata_v[l] = 32'hDEADBEEF;
    a0 = acc_cnt[l];
    wait_accept(l, a0);
    c1 = acc_cyc[l];
    req_we_v[l] = 1'b0; wdata_v[l] = 32'h0;
    a0 = acc_cnt[l];
    wait_accept(l, a0);
    check("b2b_gap", l, 32'(acc_cyc[l] - c1), 32'd1);
    req_valid_v[l] = 1'b0;
    wait_rsp(l, d, e, lat);
    check("b2b_data", l, d, 32'hDEADBEEF);
    do_req(l, 1'b0, 3'b011, 32'h0, 32'h0, d, e, lat);
    check("f3_011_err", l, 32'(e), 32'd1);
    check("f3_011_data", l, d, 32'h0);
    do_req(l, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, d, e, lat);
    do_req(l, 1'b1, 3'b010, 32'h2, 32'h11223344, d, e, lat);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    check("sw2_err", l, 32'(e), 32'd1);
    do_req(l, 1'b0, 3'b010, 32'h0, 32'h0, d, e, lat);
    check("word0_kept", l, d, 32'hCAFEF00D);
`else
    check("sw2_err", l, 32'(e), 32'd0);
    do_req(l, 1'b0, 3'b010, 32'h0, 32'h0, d, e, lat);
    check("word0_written", l, d, 32'h11223344);
`endif
  endtask

  initial begin
    logic [31:0] d;
    bit e;
    int lat, a0, seen;
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    bit e;
    int lat, a0, seen;
    for (int l = 0; l < 2; l++) begin
      req_valid_v[l] = 1'b0; req_we_v[l] = 1'b0; f3_v[l] = 3'b000;
      addr_v[l] = 32'h0; wdata_v[l] = 32'h0;
      pend_v[l] = 1'b0; pend_due[l] = 0; pend_data[l] = 32'h0; pend_err[l] = 1'b0;
      acc_cnt[l] = 0; acc_cyc[l] = 0;
      for (int i = 0; i < BYTES; i++) mm[l][i] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int l = 0; l < 2; l++) begin
      check("reset_ready", l, 32'(ready_v[l]), 32'd1);
      check("reset_valid", l, 32'(rsp_valid_v[l]), 32'd0);
      check("reset_data", l, rsp_data_v[l], 32'h0);
      check("reset_err", l, 32'(rsp_err_v[l]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    directed(0);
    directed(1);

    // reset during WAIT on the latency-3 instance
    do_req(1, 1'b1, 3'b010, 32'h20, 32'h55AA00FF, d, e, lat);
    @(negedge clk);
    req_valid_v[1] = 1'b1; req_we_v[1] = 1'b0; f3_v[1] = 3'b010; addr_v[1] = 32'h20;
    a0 = acc_cnt[1];
    wait_accept(1, a0);
    req_valid_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wait_ready", 1, 32'(ready_v[1]), 32'd1);
    check("rst_wait_data", 1, rsp_data_v[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid_v[1]) seen++;
    end
    check("rst_wait_no_rsp", 1, 32'(seen), 32'd0);
    do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat);
    check("rst_mem_kept", 1, d, 32'h55AA00FF);

    // randomized traffic on both instances
    repeat (3000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int l = 0; l < 2; l++) begin
        req_valid_v[l] = ($urandom_range(0, 2) != 0);
        req_we_v[l]    = $urandom_range(0, 1) == 1;
        f3_v[l]        = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                     : 3'($urandom_range(0, 2)) | (req_we_v[l] ? 3'b000 : 3'($urandom_range(0, 1) << 2));
        addr_v[l]      = ($urandom_range(0, 15) == 0) ? $urandom
                                                      : ((32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 63)));
        wdata_v[l]     = $urandom;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid_v[0] = 1'b0;
    req_valid_v[1] = 1'b0;
    repeat (6) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
